// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, default widths and the decimal range limit.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          BIN_W_DEF  = 14;
    localparam int          DIGITS_DEF = 4;
    localparam logic [31:0] BCD_LIMIT  = 32'd9999;

    // Largest value representable in the given number of BCD digits (10^digits - 1).
    function automatic logic [31:0] bcd_limit(input int digits);
        logic [31:0] pow;
        pow = 32'd1;
        for (int i = 0; i < digits; i++) begin
            pow = pow * 32'd10;
        end
        return pow - 32'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per cycle,
// result and overflow flag registered and held until the next conversion.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam logic [31:0]       LIMIT     = bcd_limit(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
    localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    state_t             state;
    state_t             next_state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_flag;
    logic               in_ovf;

    assign in_ovf = (32'(i_bin) > LIMIT);

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[4*d +: 4]),
            .adjusted (scratch_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (i_start) next_state = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A carry out of the top digit also means the value exceeded the decimal range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_sr   <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            ovf_flag <= 1'b0;
            o_bcd    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_busy <= (next_state != IDLE);
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        bin_sr   <= i_bin;
                        scratch  <= '0;
                        bit_cnt  <= CNT_LOAD;
                        ovf_flag <= in_ovf;
                    end
                end
                SHIFT: begin
                    scratch  <= {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr   <= bin_sr << 1;
                    bit_cnt  <= bit_cnt - CNT_W'(1);
                    ovf_flag <= ovf_flag | scratch_adj[BCD_W-1];
                end
                DONE: begin
                    o_bcd  <= ovf_flag ? ALL_NINES : scratch;
                    o_ovf  <= ovf_flag;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
